// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with combinational hit path and a
// single-outstanding line refill engine on a req/gnt + rvalid memory bus.
module icache_dm #(
    parameter int XLEN       = 32,
    parameter int NB_LINES   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] icache_adr_i,
    output logic [31:0]     icache_instr_o,
    output logic            icache_valid_o,
    input  logic            flush_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rdata_i
);

    localparam int OFFW = $clog2(LINE_WORDS);
    localparam int IDXW = $clog2(NB_LINES);
    localparam int TAGW = XLEN - OFFW - IDXW - 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [XLEN-1:0] line_adr_reg;
    logic [OFFW-1:0] beat_reg;
    logic            poison_reg;

    // Storage: tags and data are never reset; only the valid bits are.
    logic [31:0]      data_mem [0:NB_LINES*LINE_WORDS-1];
    logic [TAGW-1:0]  tag_mem  [0:NB_LINES-1];
    logic [NB_LINES-1:0] valid_vec;

    logic [OFFW-1:0] adr_off;
    logic [IDXW-1:0] adr_idx;
    logic [TAGW-1:0] adr_tag;
    logic [IDXW-1:0] refill_idx;
    logic [TAGW-1:0] refill_tag;
    logic            hit;
    logic            launch;
    logic            beat_fire;
    logic            last_beat;
    logic            unused_adr_bits;

    assign adr_off    = icache_adr_i[OFFW+1:2];
    assign adr_idx    = icache_adr_i[OFFW+IDXW+1:OFFW+2];
    assign adr_tag    = icache_adr_i[XLEN-1:OFFW+IDXW+2];
    assign refill_idx = line_adr_reg[OFFW+IDXW+1:OFFW+2];
    assign refill_tag = line_adr_reg[XLEN-1:OFFW+IDXW+2];
    assign unused_adr_bits = ^icache_adr_i[1:0];

    assign hit       = valid_vec[adr_idx] && (tag_mem[adr_idx] == adr_tag);
    assign launch    = (state_reg == IDLE) && !hit && !flush_i;
    assign beat_fire = (state_reg == REFILL) && mem_rvalid_i;
    assign last_beat = beat_fire && (&beat_reg);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch)    state_next = REQ;
            REQ:     if (mem_gnt_i) state_next = REFILL;
            REFILL:  if (last_beat) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // FSM outputs and lookup result
    always_comb begin
        mem_req_o      = (state_reg == REQ);
        mem_adr_o      = line_adr_reg;
        icache_valid_o = hit;
        icache_instr_o = NOP;
        if (hit) begin
            icache_instr_o = data_mem[{adr_idx, adr_off}];
        end
    end

    // Refill bookkeeping: latched line, beat counter, flush poison flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_adr_reg <= '0;
            beat_reg     <= '0;
            poison_reg   <= 1'b0;
        end else begin
            if (launch) begin
                line_adr_reg <= {icache_adr_i[XLEN-1:OFFW+2], {(OFFW+2){1'b0}}};
            end
            case (state_reg)
                IDLE: begin
                    poison_reg <= 1'b0;
                    beat_reg   <= '0;
                end
                REQ: begin
                    if (flush_i)   poison_reg <= 1'b1;
                    if (mem_gnt_i) beat_reg   <= '0;
                end
                REFILL: begin
                    if (flush_i) poison_reg <= 1'b1;
                    if (mem_rvalid_i) begin
                        beat_reg <= last_beat ? '0 : beat_reg + 1'b1;
                    end
                end
                default: begin
                    beat_reg <= '0;
                end
            endcase
        end
    end

    // Data and tag writes; the write port is never bypassed to the read side
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            data_mem[{refill_idx, beat_reg}] <= mem_rdata_i;
        end
        if (last_beat) begin
            tag_mem[refill_idx] <= refill_tag;
        end
    end

    // Per-line valid bits: flush wins over a completing refill
    for (genvar gi = 0; gi < NB_LINES; gi++) begin : g_line
        logic line_valid_reg;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                line_valid_reg <= 1'b0;
            end else if (flush_i) begin
                line_valid_reg <= 1'b0;
            end else if (last_beat && !poison_reg && (refill_idx == IDXW'(gi))) begin
                line_valid_reg <= 1'b1;
            end
        end

        assign valid_vec[gi] = line_valid_reg;
    end

endmodule
